zpulse_gate_ctrl: RTL and testbench

Gate sequencer for the 8-digit BCD photon pulse counter. Enables the counter for a commanded number of fixed-length gate windows, or continuously. Captures each completed window's digits and overflow into a one-entry output register with a valid/ready handshake toward the display/waveform path. Supervises the counter's update strobe with a watchdog.

---
 rtl/zpulse_pkg.sv | 21 ++
 rtl/zpulse_gate_ctrl_if.sv | 35 +++
 rtl/zpulse_sample_reg.sv | 77 +++++++
 rtl/zpulse_gate_ctrl.sv | 143 ++++++++++++++
 tb/tb_zpulse_gate_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zpulse_pkg.sv
// Shared types and constants for the BCD photon pulse counter gate sequencer.
package zpulse_pkg;

   localparam int unsigned ZPC_PERIOD = 80_000;
   localparam int unsigned ZPC_DIGITS = 8;
   localparam int unsigned ZPC_BCD_W  = 4 * ZPC_DIGITS;
   localparam logic [ZPC_BCD_W-1:0] ZPC_SAT_VALUE = 32'h9999_9999;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StErr   = 2'd3
   } zpc_state_t;

   // Bits needed to hold the values 0..max_val.
   function automatic int unsigned zpc_cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/zpulse_gate_ctrl_if.sv
// Command, counter and sample-handshake bundle between the gate sequencer and its host.
interface zpulse_gate_ctrl_if #(
   parameter int unsigned GATES_W = 16,
   parameter int unsigned LOST_W  = 8
) ();
   import zpulse_pkg::*;

   logic                 cmd_start;
   logic                 cmd_stop;
   logic [GATES_W-1:0]   gate_num;
   logic [ZPC_BCD_W-1:0] cnt_bcd;
   logic                 cnt_ovf;
   logic                 cnt_update;
   logic                 cnt_en;
   logic [ZPC_BCD_W-1:0] smp_bcd;
   logic                 smp_ovf;
   logic [GATES_W-1:0]   smp_idx;
   logic                 smp_valid;
   logic                 smp_ready;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [LOST_W-1:0]    lost_cnt;

   modport master (
      output cmd_start, cmd_stop, gate_num, cnt_bcd, cnt_ovf, cnt_update, smp_ready,
      input  cnt_en, smp_bcd, smp_ovf, smp_idx, smp_valid, busy, done, err, lost_cnt
   );

   modport slave (
      input  cmd_start, cmd_stop, gate_num, cnt_bcd, cnt_ovf, cnt_update, smp_ready,
      output cnt_en, smp_bcd, smp_ovf, smp_idx, smp_valid, busy, done, err, lost_cnt
   );

endinterface

// File: rtl/zpulse_sample_reg.sv
// One-entry valid/ready capture register; a capture into a stalled full entry is dropped
// and counted in a saturating lost counter.
module zpulse_sample_reg
   import zpulse_pkg::*;
#(
   parameter int unsigned GATES_W = 16,
   parameter int unsigned LOST_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cap_i,
   input  logic [ZPC_BCD_W-1:0] cap_bcd_i,
   input  logic                 cap_ovf_i,
   input  logic [GATES_W-1:0]   cap_idx_i,
   input  logic                 clr_lost_i,
   input  logic                 ready_i,
   output logic [ZPC_BCD_W-1:0] bcd_o,
   output logic                 ovf_o,
   output logic [GATES_W-1:0]   idx_o,
   output logic                 valid_o,
   output logic [LOST_W-1:0]    lost_o
);

   logic [ZPC_BCD_W-1:0] bcd_q, bcd_d;
   logic                 ovf_q, ovf_d;
   logic [GATES_W-1:0]   idx_q, idx_d;
   logic                 valid_q, valid_d;
   logic [LOST_W-1:0]    lost_q, lost_d;
   logic                 load, drop;

   assign load = cap_i & (~valid_q | ready_i);
   assign drop = cap_i & valid_q & ~ready_i;

   always_comb begin
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      lost_d  = lost_q;
      if (load) begin
         bcd_d   = cap_bcd_i;
         ovf_d   = cap_ovf_i;
         idx_d   = cap_idx_i;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (clr_lost_i) begin
         lost_d = '0;
      end else if (drop && (lost_q != {LOST_W{1'b1}})) begin
         lost_d = lost_q + LOST_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         lost_q  <= '0;
      end else begin
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         lost_q  <= lost_d;
      end
   end

   assign bcd_o   = bcd_q;
   assign ovf_o   = ovf_q;
   assign idx_o   = idx_q;
   assign valid_o = valid_q;
   assign lost_o  = lost_q;

endmodule

// File: rtl/zpulse_gate_ctrl.sv
// Gate sequencer for the 8-digit BCD photon pulse counter: window countdown, capture, watchdog.
// Define ZPULSE_SAT_EN to load the saturated reading 9999_9999 on overflowed windows.
module zpulse_gate_ctrl
   import zpulse_pkg::*;
#(
   parameter int unsigned GATES_W  = 16,
   parameter int unsigned LOST_W   = 8,
   parameter int unsigned WDOG_CYC = 80_004
) (
   input logic               clk,
   input logic               rst,
   zpulse_gate_ctrl_if.slave zif
);

   localparam int unsigned WdogW = zpc_cnt_width(WDOG_CYC);
   localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYC - 1);

   zpc_state_t           state_q, state_d;
   logic [GATES_W-1:0]   remaining_q, remaining_d;
   logic                 cont_q, cont_d;
   logic [GATES_W-1:0]   idx_q, idx_d;
   logic                 ovf_sticky_q, ovf_sticky_d;
   logic [WdogW-1:0]     wdog_q, wdog_d;
   logic                 cnt_en_q, cnt_en_d;
   logic                 done_q, done_d;

   logic                 start_acc, capture, last_cap, wdog_exp;
   logic                 cap_ovf;
   logic [ZPC_BCD_W-1:0] cap_bcd;
   logic                 smp_valid;

   assign start_acc = (state_q == StIdle) & zif.cmd_start & ~zif.cmd_stop;
   assign capture   = (state_q == StRun) & zif.cnt_update;
   assign last_cap  = capture & ~cont_q & (remaining_q == GATES_W'(1));
   assign wdog_exp  = (state_q == StRun) & ~zif.cnt_update & (wdog_q == WdogLast);
   assign cap_ovf   = ovf_sticky_q | zif.cnt_ovf;

`ifdef ZPULSE_SAT_EN
   assign cap_bcd = cap_ovf ? ZPC_SAT_VALUE : zif.cnt_bcd;
`else
   assign cap_bcd = zif.cnt_bcd;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_acc) state_d = StRun;
         StRun: begin
            // A capture coincident with stop is still taken; stop only ends the run.
            if (last_cap || zif.cmd_stop) state_d = StDrain;
            else if (wdog_exp)            state_d = StErr;
         end
         StDrain: if (!smp_valid) state_d = StIdle;
         StErr:   if (zif.cmd_stop) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      zif.busy = (state_q != StIdle);
      zif.err  = (state_q == StErr);
      cnt_en_d = (state_d == StRun);
      done_d   = (state_q == StDrain) && (state_d == StIdle);
   end

   always_comb begin
      remaining_d  = remaining_q;
      cont_d       = cont_q;
      idx_d        = idx_q;
      ovf_sticky_d = ovf_sticky_q;
      wdog_d       = wdog_q;
      if (start_acc) begin
         remaining_d  = zif.gate_num;
         cont_d       = (zif.gate_num == '0);
         idx_d        = '0;
         ovf_sticky_d = 1'b0;
         wdog_d       = '0;
      end else if (state_q == StRun) begin
         if (capture) begin
            idx_d        = idx_q + GATES_W'(1);
            ovf_sticky_d = 1'b0;
            wdog_d       = '0;
            if (!cont_q) remaining_d = remaining_q - GATES_W'(1);
         end else begin
            wdog_d = wdog_q + WdogW'(1);
            if (zif.cnt_ovf) ovf_sticky_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining_q  <= '0;
         cont_q       <= 1'b0;
         idx_q        <= '0;
         ovf_sticky_q <= 1'b0;
         wdog_q       <= '0;
         cnt_en_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         remaining_q  <= remaining_d;
         cont_q       <= cont_d;
         idx_q        <= idx_d;
         ovf_sticky_q <= ovf_sticky_d;
         wdog_q       <= wdog_d;
         cnt_en_q     <= cnt_en_d;
         done_q       <= done_d;
      end
   end

   assign zif.cnt_en = cnt_en_q;
   assign zif.done   = done_q;

   zpulse_sample_reg #(
      .GATES_W (GATES_W),
      .LOST_W  (LOST_W)
   ) u_sample_reg (
      .clk        (clk),
      .rst        (rst),
      .cap_i      (capture),
      .cap_bcd_i  (cap_bcd),
      .cap_ovf_i  (cap_ovf),
      .cap_idx_i  (idx_q),
      .clr_lost_i (start_acc),
      .ready_i    (zif.smp_ready),
      .bcd_o      (zif.smp_bcd),
      .ovf_o      (zif.smp_ovf),
      .idx_o      (zif.smp_idx),
      .valid_o    (smp_valid),
      .lost_o     (zif.lost_cnt)
   );

   assign zif.smp_valid = smp_valid;

endmodule

// File: tb/tb_zpulse_gate_ctrl.sv
// Directed bench for zpulse_gate_ctrl with a shortened counter period and watchdog.
module tb_zpulse_gate_ctrl;

   localparam int unsigned P = 20;
   localparam int unsigned W = 24;
`ifdef ZPULSE_SAT_EN
   localparam logic [31:0] OvfBcdExp = 32'h9999_9999;
`else
   localparam logic [31:0] OvfBcdExp = 32'h0000_0012;
`endif

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   zpulse_gate_ctrl_if #(.GATES_W(16), .LOST_W(8)) zif ();

   zpulse_gate_ctrl #(
      .GATES_W  (16),
      .LOST_W   (8),
      .WDOG_CYC (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .zif (zif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_start(input logic [15:0] n);
      zif.gate_num  = n;
      zif.cmd_start = 1'b1;
      step();
      zif.cmd_start = 1'b0;
      zif.gate_num  = 16'hFFFF;
   endtask

   task automatic do_window(input logic [31:0] bcd, input logic stop);
      repeat (P - 1) step();
      zif.cnt_bcd    = bcd;
      zif.cnt_update = 1'b1;
      zif.cmd_stop   = stop;
      step();
      zif.cnt_update = 1'b0;
      zif.cmd_stop   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests++;
      if ({zif.cnt_en, zif.busy, zif.done, zif.err, zif.smp_valid, zif.smp_ovf} !== 6'b0) begin
         $display("FAIL reset_flags: got %b, expected 000000",
                  {zif.cnt_en, zif.busy, zif.done, zif.err, zif.smp_valid, zif.smp_ovf});
         fails++;
      end
      tests++;
      if ({zif.smp_bcd, zif.smp_idx, zif.lost_cnt} !== 56'h0) begin
         $display("FAIL reset_data: got bcd=%h idx=%0d lost=%0d, expected 0",
                  zif.smp_bcd, zif.smp_idx, zif.lost_cnt);
         fails++;
      end
      rst = 1'b0;
      step();
      zif.cmd_start = 1'b1;
      zif.cmd_stop  = 1'b1;
      step();
      zif.cmd_start = 1'b0;
      zif.cmd_stop  = 1'b0;
      tests++;
      if (zif.busy !== 1'b0) begin
         $display("FAIL start_with_stop: got busy=%b, expected 0", zif.busy);
         fails++;
      end
   endtask

   task automatic test_gate3();
      int dones;
      zif.smp_ready = 1'b1;
      do_start(16'd3);
      tests++;
      if ({zif.busy, zif.cnt_en} !== 2'b11) begin
         $display("FAIL gate3_start: got busy,cnt_en=%b, expected 11", {zif.busy, zif.cnt_en});
         fails++;
      end
      for (int w = 0; w < 3; w++) begin
         do_window(32'h0000_0100 + 32'(w), 1'b0);
         tests++;
         if ({zif.smp_valid, zif.smp_idx, zif.smp_bcd} !== {1'b1, 16'(w), 32'h0000_0100 + 32'(w)})
         begin
            $display("FAIL gate3_sample w=%0d: got v=%b idx=%0d bcd=%h, expected v=1 idx=%0d",
                     w, zif.smp_valid, zif.smp_idx, zif.smp_bcd, w);
            fails++;
         end
         tests++;
         if (zif.cnt_en !== 1'(w < 2)) begin
            $display("FAIL gate3_cnt_en w=%0d: got %b, expected %b", w, zif.cnt_en, w < 2);
            fails++;
         end
      end
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (zif.done === 1'b1) dones++;
         step();
      end
      tests++;
      if (dones != 1 || zif.busy !== 1'b0 || zif.lost_cnt !== 8'd0) begin
         $display("FAIL gate3_end: got dones=%0d busy=%b lost=%0d, expected 1 0 0",
                  dones, zif.busy, zif.lost_cnt);
         fails++;
      end
   endtask

   task automatic test_hold_drop();
      zif.smp_ready = 1'b0;
      do_start(16'd0);
      do_window(32'h0000_0011, 1'b0);
      tests++;
      if ({zif.smp_valid, zif.smp_idx, zif.smp_bcd} !== {1'b1, 16'd0, 32'h0000_0011}) begin
         $display("FAIL hold_first: got v=%b idx=%0d bcd=%h, expected v=1 idx=0 bcd=00000011",
                  zif.smp_valid, zif.smp_idx, zif.smp_bcd);
         fails++;
      end
      do_window(32'h0000_0022, 1'b0);
      tests++;
      if ({zif.smp_valid, zif.smp_idx, zif.smp_bcd, zif.lost_cnt} !==
          {1'b1, 16'd0, 32'h0000_0011, 8'd1}) begin
         $display("FAIL hold_drop: got v=%b idx=%0d bcd=%h lost=%0d, expected 1 0 00000011 1",
                  zif.smp_valid, zif.smp_idx, zif.smp_bcd, zif.lost_cnt);
         fails++;
      end
      zif.smp_ready = 1'b1;
      step();
      tests++;
      if ({zif.smp_valid, zif.lost_cnt, zif.busy} !== {1'b0, 8'd1, 1'b1}) begin
         $display("FAIL hold_accept: got v=%b lost=%0d busy=%b, expected 0 1 1",
                  zif.smp_valid, zif.lost_cnt, zif.busy);
         fails++;
      end
      zif.cmd_stop = 1'b1;
      step();
      zif.cmd_stop = 1'b0;
      for (int i = 0; i < 10 && zif.busy === 1'b1; i++) step();
      tests++;
      if (zif.busy !== 1'b0) begin
         $display("FAIL hold_stop_idle: got busy=%b, expected 0", zif.busy);
         fails++;
      end
   endtask

   task automatic test_ovf();
      zif.smp_ready = 1'b1;
      do_start(16'd2);
      tests++;
      if (zif.lost_cnt !== 8'd0) begin
         $display("FAIL ovf_lost_clr: got %0d, expected 0", zif.lost_cnt);
         fails++;
      end
      repeat (5) step();
      zif.cnt_ovf = 1'b1;
      step();
      zif.cnt_ovf = 1'b0;
      repeat (P - 7) step();
      zif.cnt_bcd    = 32'h0000_0012;
      zif.cnt_update = 1'b1;
      step();
      zif.cnt_update = 1'b0;
      tests++;
      if ({zif.smp_valid, zif.smp_ovf, zif.smp_bcd} !== {1'b1, 1'b1, OvfBcdExp}) begin
         $display("FAIL ovf_capture: got v=%b ovf=%b bcd=%h, expected 1 1 %h",
                  zif.smp_valid, zif.smp_ovf, zif.smp_bcd, OvfBcdExp);
         fails++;
      end
      do_window(32'h0000_0034, 1'b0);
      tests++;
      if ({zif.smp_ovf, zif.smp_bcd, zif.smp_idx} !== {1'b0, 32'h0000_0034, 16'd1}) begin
         $display("FAIL ovf_next: got ovf=%b bcd=%h idx=%0d, expected 0 00000034 1",
                  zif.smp_ovf, zif.smp_bcd, zif.smp_idx);
         fails++;
      end
      for (int i = 0; i < 10 && zif.busy === 1'b1; i++) step();
      tests++;
      if (zif.busy !== 1'b0) begin
         $display("FAIL ovf_idle: got busy=%b, expected 0", zif.busy);
         fails++;
      end
   endtask

   task automatic test_stop_update();
      int dones;
      zif.smp_ready = 1'b1;
      do_start(16'd5);
      do_window(32'h0000_0077, 1'b1);
      tests++;
      if ({zif.smp_valid, zif.smp_bcd, zif.cnt_en, zif.busy} !==
          {1'b1, 32'h0000_0077, 1'b0, 1'b1}) begin
         $display("FAIL stop_upd_capture: got v=%b bcd=%h cnt_en=%b busy=%b, expected 1 77 0 1",
                  zif.smp_valid, zif.smp_bcd, zif.cnt_en, zif.busy);
         fails++;
      end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (zif.done === 1'b1) dones++;
         step();
      end
      tests++;
      if (dones != 1 || zif.busy !== 1'b0) begin
         $display("FAIL stop_upd_done: got dones=%0d busy=%b, expected 1 0", dones, zif.busy);
         fails++;
      end
   endtask

   task automatic test_wdog();
      zif.smp_ready = 1'b1;
      do_start(16'd0);
      do_window(32'h0000_0042, 1'b0);
      repeat (W - 1) step();
      tests++;
      if ({zif.err, zif.busy, zif.cnt_en} !== 3'b011) begin
         $display("FAIL wdog_early: got err,busy,cnt_en=%b, expected 011",
                  {zif.err, zif.busy, zif.cnt_en});
         fails++;
      end
      step();
      tests++;
      if ({zif.err, zif.busy, zif.cnt_en} !== 3'b110) begin
         $display("FAIL wdog_fire: got err,busy,cnt_en=%b, expected 110",
                  {zif.err, zif.busy, zif.cnt_en});
         fails++;
      end
      zif.gate_num  = 16'd3;
      zif.cmd_start = 1'b1;
      step();
      zif.cmd_start = 1'b0;
      step();
      tests++;
      if ({zif.err, zif.cnt_en} !== 2'b10) begin
         $display("FAIL wdog_start_ignored: got err,cnt_en=%b, expected 10",
                  {zif.err, zif.cnt_en});
         fails++;
      end
      zif.cmd_stop = 1'b1;
      step();
      zif.cmd_stop = 1'b0;
      tests++;
      if ({zif.err, zif.busy, zif.done} !== 3'b000) begin
         $display("FAIL wdog_stop: got err,busy,done=%b, expected 000",
                  {zif.err, zif.busy, zif.done});
         fails++;
      end
      step();
      tests++;
      if (zif.done !== 1'b0) begin
         $display("FAIL wdog_no_done: got done=%b, expected 0", zif.done);
         fails++;
      end
   endtask

   task automatic test_async_reset();
      int dones;
      zif.smp_ready = 1'b0;
      do_start(16'd0);
      do_window(32'h0000_0055, 1'b0);
      tests++;
      if (zif.smp_valid !== 1'b1) begin
         $display("FAIL arst_pre: got v=%b, expected 1", zif.smp_valid);
         fails++;
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({zif.cnt_en, zif.busy, zif.done, zif.err, zif.smp_valid, zif.smp_ovf,
           zif.smp_bcd, zif.smp_idx, zif.lost_cnt} !== 62'h0) begin
         $display("FAIL arst_immediate: got en=%b busy=%b v=%b bcd=%h idx=%0d, expected all 0",
                  zif.cnt_en, zif.busy, zif.smp_valid, zif.smp_bcd, zif.smp_idx);
         fails++;
      end
      step();
      rst = 1'b0;
      zif.smp_ready = 1'b1;
      do_start(16'd1);
      do_window(32'h0000_0066, 1'b0);
      tests++;
      if ({zif.smp_valid, zif.smp_idx, zif.smp_bcd, zif.cnt_en} !==
          {1'b1, 16'd0, 32'h0000_0066, 1'b0}) begin
         $display("FAIL arst_restart: got v=%b idx=%0d bcd=%h cnt_en=%b, expected 1 0 66 0",
                  zif.smp_valid, zif.smp_idx, zif.smp_bcd, zif.cnt_en);
         fails++;
      end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (zif.done === 1'b1) dones++;
         step();
      end
      tests++;
      if (dones != 1 || zif.busy !== 1'b0) begin
         $display("FAIL arst_done: got dones=%0d busy=%b, expected 1 0", dones, zif.busy);
         fails++;
      end
   endtask

   initial begin
      tests          = 0;
      fails          = 0;
      rst            = 1'b1;
      zif.cmd_start  = 1'b0;
      zif.cmd_stop   = 1'b0;
      zif.gate_num   = '0;
      zif.cnt_bcd    = '0;
      zif.cnt_ovf    = 1'b0;
      zif.cnt_update = 1'b0;
      zif.smp_ready  = 1'b0;
      test_reset();
      test_gate3();
      test_hold_drop();
      test_ovf();
      test_stop_update();
      test_wdog();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
